// File: rtl/enemy_wave_controller.sv
// Enemy formation engine: loads a V formation one enemy per cycle, moves it on a
// prescaled tick, retires enemies on accepted kills and respawns a cleared wave.
module enemy_wave_controller #(
    parameter int unsigned N_ENEMY       = 17,
    parameter int unsigned COORD_W       = 10,
    parameter int unsigned SCREEN_H      = 480,
    parameter int unsigned X_SPACING     = 38,
    parameter int unsigned Y_SPACING     = 4,
    parameter int unsigned TICK_DIV      = 131072,
    parameter int unsigned STEP_Y        = 2,
    parameter int unsigned MODE          = 0,
    parameter int unsigned STEP_X        = 1,
    parameter int unsigned ZIG_TICKS     = 16,
    parameter int unsigned RESPAWN_TICKS = 64
) (
    input  logic                         clk25,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         kill_valid,
    input  logic [4:0]                   kill_idx,
    output logic [N_ENEMY*COORD_W-1:0]   fly_x_flat,
    output logic [N_ENEMY*COORD_W-1:0]   fly_y_flat,
    output logic [N_ENEMY-1:0]           fly_alive_flat,
    output logic                         move_tick,
    output logic                         wave_done,
    output logic [15:0]                  kill_count
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned ZW = (ZIG_TICKS > 1) ? $clog2(ZIG_TICKS) : 1;
    localparam int unsigned RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam int unsigned IW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StRun   = 2'd1,
        StClear = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        load_idx_q, load_idx_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;
    logic                 dir_q, dir_d;
    logic [ZW-1:0]        zig_q, zig_d;
    logic [RW-1:0]        resp_q, resp_d;
    logic [15:0]          kills_q, kills_d;
    logic [N_ENEMY-1:0]   alive_q, alive_d;
    logic [COORD_W-1:0]   x_q [N_ENEMY];
    logic [COORD_W-1:0]   x_d [N_ENEMY];
    logic [COORD_W-1:0]   y_q [N_ENEMY];
    logic [COORD_W-1:0]   y_d [N_ENEMY];

    logic [31:0]          load_k;
    logic [COORD_W-1:0]   init_x, init_y;
    logic [31:0]          alive_pad;
    logic                 kill_ok;

    // Wider intermediate so the wrap test sees the carry.
    function automatic logic [COORD_W-1:0] y_next(input logic [COORD_W-1:0] y);
        logic [COORD_W:0]   yn;
        logic [COORD_W-1:0] res;
        yn = {1'b0, y} + (COORD_W+1)'(STEP_Y);
        if (32'(yn) >= SCREEN_H) res = '0;
        else                     res = yn[COORD_W-1:0];
        return res;
    endfunction

    function automatic logic [COORD_W-1:0] x_next(input logic [COORD_W-1:0] x,
                                                   input logic               dir);
        logic [COORD_W:0]   xn;
        logic [COORD_W-1:0] res;
        xn = {1'b0, x} + (COORD_W+1)'(STEP_X);
        if (dir) begin
            res = xn[COORD_W] ? {COORD_W{1'b1}} : xn[COORD_W-1:0];
        end else if (32'(x) < STEP_X) begin
            res = '0;
        end else begin
            res = x - COORD_W'(STEP_X);
        end
        return res;
    endfunction

    // V formation: rising y up to the middle index, falling afterwards.
    always_comb begin
        load_k = 32'(load_idx_q);
        init_x = COORD_W'(load_k * X_SPACING);
        if (load_k <= (N_ENEMY - 1) / 2) init_y = COORD_W'(load_k * Y_SPACING);
        else                             init_y = COORD_W'((N_ENEMY - 1 - load_k) * Y_SPACING);
    end

    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        dir_d      = dir_q;
        zig_d      = zig_q;
        resp_d     = resp_q;
        kills_d    = kills_q;
        alive_d    = alive_q;
        x_d        = x_q;
        y_d        = y_q;
        alive_pad  = 32'(alive_q);
        kill_ok    = 1'b0;

        if (state_q != StInit && enable) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        case (state_q)
            StInit: begin
                presc_d             = '0;
                x_d[load_idx_q]     = init_x;
                y_d[load_idx_q]     = init_y;
                alive_d[load_idx_q] = 1'b1;
                if (load_idx_q == IW'(N_ENEMY - 1)) begin
                    load_idx_d = '0;
                    state_d    = StRun;
                end else begin
                    load_idx_d = load_idx_q + IW'(1);
                end
            end

            StRun: begin
                kill_ok = kill_valid && ({1'b0, kill_idx} < 6'(N_ENEMY)) && alive_pad[kill_idx];
                if (tick_q) begin
                    // A kill landing on the tick edge keeps the victim in place.
                    for (int i = 0; i < N_ENEMY; i++) begin
                        if (alive_q[i] && !(kill_ok && kill_idx == 5'(i))) begin
                            y_d[i] = y_next(y_q[i]);
                            if (MODE == 1) x_d[i] = x_next(x_q[i], dir_q);
                        end
                    end
                    if (zig_q == ZW'(ZIG_TICKS - 1)) begin
                        zig_d = '0;
                        dir_d = ~dir_q;
                    end else begin
                        zig_d = zig_q + ZW'(1);
                    end
                end
                if (kill_ok) begin
                    alive_d[kill_idx] = 1'b0;
                    if (kills_q != 16'hFFFF) kills_d = kills_q + 16'd1;
                end
                if (alive_d == '0) begin
                    state_d = StClear;
                    done_d  = 1'b1;
                    resp_d  = '0;
                end
            end

            StClear: begin
                if (tick_q) begin
                    if (resp_q == RW'(RESPAWN_TICKS - 1)) begin
                        resp_d     = '0;
                        load_idx_d = '0;
                        state_d    = StInit;
                    end else begin
                        resp_d = resp_q + RW'(1);
                    end
                end
            end

            default: begin
                state_d    = StInit;
                load_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            load_idx_q <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            dir_q      <= 1'b1;
            zig_q      <= '0;
            resp_q     <= '0;
            kills_q    <= '0;
            alive_q    <= '0;
            x_q        <= '{default: '0};
            y_q        <= '{default: '0};
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            dir_q      <= dir_d;
            zig_q      <= zig_d;
            resp_q     <= resp_d;
            kills_q    <= kills_d;
            alive_q    <= alive_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_flat
        assign fly_x_flat[g*COORD_W +: COORD_W] = x_q[g];
        assign fly_y_flat[g*COORD_W +: COORD_W] = y_q[g];
    end

    assign fly_alive_flat = alive_q;
    assign move_tick      = tick_q;
    assign wave_done      = done_q;
    assign kill_count     = kills_q;

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Scoreboard bench: a per-cycle reference model predicts every output change of a
// straight (MODE=0) and a zigzag (MODE=1) instance; monitors compare on each change.
module tb_enemy_wave_controller;

    localparam int NE = 17, CW = 10, SH = 480, XS = 38, YS = 4, TD = 4;
    localparam int SY = 2, SX = 1, ZT = 2, RT = 4;
    localparam int XMAX = (1 << CW) - 1;

    typedef struct {
        int                 cyc;
        logic [NE-1:0]      alive;
        logic [NE*CW-1:0]   x;
        logic [NE*CW-1:0]   y;
        logic [15:0]        kc;
        logic               tick;
        logic               wd;
    } snap_t;

    logic clk25 = 1'b0, rst_n = 1'b0, enable = 1'b0, kill_valid = 1'b0;
    logic [4:0] kill_idx = '0;
    logic [NE*CW-1:0] x0, y0, x1, y1;
    logic [NE-1:0] al0, al1;
    logic mt0, mt1, wd0, wd1;
    logic [15:0] kc0, kc1;

    always #5 clk25 = ~clk25;

    enemy_wave_controller #(
        .N_ENEMY(NE), .COORD_W(CW), .SCREEN_H(SH), .X_SPACING(XS), .Y_SPACING(YS),
        .TICK_DIV(TD), .STEP_Y(SY), .MODE(0), .STEP_X(SX), .ZIG_TICKS(ZT),
        .RESPAWN_TICKS(RT)
    ) u_dut0 (
        .clk25(clk25), .rst_n(rst_n), .enable(enable), .kill_valid(kill_valid),
        .kill_idx(kill_idx), .fly_x_flat(x0), .fly_y_flat(y0), .fly_alive_flat(al0),
        .move_tick(mt0), .wave_done(wd0), .kill_count(kc0)
    );

    enemy_wave_controller #(
        .N_ENEMY(NE), .COORD_W(CW), .SCREEN_H(SH), .X_SPACING(XS), .Y_SPACING(YS),
        .TICK_DIV(TD), .STEP_Y(SY), .MODE(1), .STEP_X(SX), .ZIG_TICKS(ZT),
        .RESPAWN_TICKS(RT)
    ) u_dut1 (
        .clk25(clk25), .rst_n(rst_n), .enable(enable), .kill_valid(kill_valid),
        .kill_idx(kill_idx), .fly_x_flat(x1), .fly_y_flat(y1), .fly_alive_flat(al1),
        .move_tick(mt1), .wave_done(wd1), .kill_count(kc1)
    );

    int errors = 0, checks = 0, cyc = 0;
    bit mon_on = 1'b0;

    // Reference model state, index 0 = straight instance, 1 = zigzag instance.
    int mx [2][NE];
    int my [2][NE];
    bit mal [2][NE];
    int ph [2], ld [2], presc [2], kc [2], zc [2], rc [2];
    bit tk [2], wdm [2], dir [2];
    snap_t mprev [2];
    snap_t q0 [$];
    snap_t q1 [$];

    task automatic chk(input string name, input logic [NE*CW-1:0] act,
                       input logic [NE*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_event(input snap_t a, input snap_t b);
        return a.tick || a.wd || a.alive !== b.alive || a.x !== b.x || a.y !== b.y
               || a.kc !== b.kc;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            ph[m] = 0; ld[m] = 0; presc[m] = 0; kc[m] = 0; zc[m] = 0; rc[m] = 0;
            tk[m] = 0; wdm[m] = 0; dir[m] = 1;
            for (int i = 0; i < NE; i++) begin
                mx[m][i] = 0; my[m][i] = 0; mal[m][i] = 0;
            end
            mprev[m] = '{cyc: 0, alive: '0, x: '0, y: '0, kc: '0, tick: 1'b0, wd: 1'b0};
        end
    endfunction

    task automatic model_step(input int m, input bit en, input bit kv, input int ki);
        bit nt, nw, acc, any;
        snap_t s;
        nt = 0; nw = 0; acc = 0;
        if (ph[m] == 0) begin
            mx[m][ld[m]] = ld[m] * XS;
            my[m][ld[m]] = (ld[m] <= (NE - 1) / 2) ? ld[m] * YS : (NE - 1 - ld[m]) * YS;
            mal[m][ld[m]] = 1;
            presc[m] = 0;
            if (ld[m] == NE - 1) begin ph[m] = 1; ld[m] = 0; end
            else ld[m]++;
        end else begin
            if (en) begin
                if (presc[m] == TD - 1) begin presc[m] = 0; nt = 1; end
                else presc[m]++;
            end
            if (ph[m] == 1) begin
                if (kv && ki < NE) acc = mal[m][ki];
                if (tk[m]) begin
                    for (int i = 0; i < NE; i++) begin
                        if (mal[m][i] && !(acc && ki == i)) begin
                            my[m][i] = (my[m][i] + SY >= SH) ? 0 : my[m][i] + SY;
                            if (m == 1) begin
                                if (dir[m]) mx[m][i] = (mx[m][i] + SX > XMAX) ? XMAX : mx[m][i] + SX;
                                else        mx[m][i] = (mx[m][i] < SX) ? 0 : mx[m][i] - SX;
                            end
                        end
                    end
                    if (zc[m] == ZT - 1) begin zc[m] = 0; dir[m] = !dir[m]; end
                    else zc[m]++;
                end
                if (acc) begin
                    mal[m][ki] = 0;
                    if (kc[m] < 65535) kc[m]++;
                end
                any = 0;
                for (int i = 0; i < NE; i++) any |= mal[m][i];
                if (!any) begin ph[m] = 2; nw = 1; rc[m] = 0; end
            end else if (tk[m]) begin
                if (rc[m] == RT - 1) begin rc[m] = 0; ph[m] = 0; ld[m] = 0; end
                else rc[m]++;
            end
        end
        tk[m] = nt;
        wdm[m] = nw;
        s.cyc = cyc;
        for (int i = 0; i < NE; i++) begin
            s.alive[i] = mal[m][i];
            s.x[i*CW +: CW] = CW'(mx[m][i]);
            s.y[i*CW +: CW] = CW'(my[m][i]);
        end
        s.kc = 16'(kc[m]);
        s.tick = tk[m];
        s.wd = wdm[m];
        if (is_event(s, mprev[m])) begin
            if (m == 0) q0.push_back(s);
            else        q1.push_back(s);
        end
        mprev[m] = s;
    endtask

    initial begin
        forever begin
            @(posedge clk25);
            cyc++;
            if (rst_n) begin
                model_step(0, enable, kill_valid, int'(kill_idx));
                model_step(1, enable, kill_valid, int'(kill_idx));
            end
        end
    end

    task automatic sb_check(input int m, input snap_t a);
        snap_t e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL sb%0d.unexpected: got output event at cycle %0d expected none",
                     m, a.cyc);
            return;
        end
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb%0d.cycle", m), a.cyc, e.cyc);
        chk($sformatf("sb%0d.alive@%0d", m, e.cyc), a.alive, e.alive);
        chk($sformatf("sb%0d.x@%0d", m, e.cyc), a.x, e.x);
        chk($sformatf("sb%0d.y@%0d", m, e.cyc), a.y, e.y);
        chk($sformatf("sb%0d.kill_count@%0d", m, e.cyc), a.kc, e.kc);
        chk($sformatf("sb%0d.move_tick@%0d", m, e.cyc), a.tick, e.tick);
        chk($sformatf("sb%0d.wave_done@%0d", m, e.cyc), a.wd, e.wd);
    endtask

    snap_t c0, c1, p0, p1;
    initial begin
        p0 = '{cyc: 0, alive: '0, x: '0, y: '0, kc: '0, tick: 1'b0, wd: 1'b0};
        p1 = p0;
        forever begin
            @(negedge clk25);
            c0 = '{cyc: cyc, alive: al0, x: x0, y: y0, kc: kc0, tick: mt0, wd: wd0};
            c1 = '{cyc: cyc, alive: al1, x: x1, y: y1, kc: kc1, tick: mt1, wd: wd1};
            if (mon_on && is_event(c0, p0)) sb_check(0, c0);
            if (mon_on && is_event(c1, p1)) sb_check(1, c1);
            p0 = c0;
            p1 = c1;
        end
    end

    task automatic drive(input bit en, input bit kv, input int ki);
        @(negedge clk25);
        enable = en;
        kill_valid = kv;
        kill_idx = 5'(ki);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk25);
        mon_on = 0;
        rst_n = 0;
        kill_valid = 0;
        enable = 0;
        #1;
        chk("reset_alive0", al0, '0);
        chk("reset_alive1", al1, '0);
        chk("reset_x1", x1, '0);
        chk("reset_y0", y0, '0);
        chk("reset_kill_count", kc0, '0);
        chk("reset_pulses", {mt0, wd0, mt1, wd1}, '0);
        repeat (n) @(negedge clk25);
        model_reset();
        q0.delete();
        q1.delete();
        rst_n = 1;
        mon_on = 1;
    endtask

    initial begin
        int pulses;
        model_reset();
        do_reset(3);

        // Formation load
        repeat (NE) drive(1, 0, 0);
        chk("load_alive0", al0, 17'h1FFFF);
        chk("load_alive1", al1, 17'h1FFFF);
        chk("load_x5", x0[5*CW +: CW], 190);
        chk("load_y5", y0[5*CW +: CW], 20);
        chk("load_y16", y0[16*CW +: CW], 0);
        chk("load_y8", y1[8*CW +: CW], 32);

        // Kill, repeated kill, out-of-range kill
        drive(1, 1, 3);
        drive(1, 1, 3);
        drive(1, 1, 20);
        drive(1, 0, 0);
        chk("kill3_count", kc0, 1);
        chk("kill3_alive", al0[3], 0);

        // Kill enemy 0 in the same cycle as a movement tick
        for (int w = 0; w < 20 && !tk[0]; w++) drive(1, 0, 0);
        checks++;
        if (!tk[0]) begin
            errors++;
            $display("FAIL tick_wait: got no move_tick in 20 cycles expected one");
        end
        kill_valid = 1;
        kill_idx = 0;
        drive(1, 0, 0);

        // Long run to exercise y wrap, then a frozen stretch
        repeat (1000) drive(1, 0, 0);
        repeat (20) drive(0, 0, 0);

        // Random traffic across several waves
        repeat (800) drive(($urandom % 8) != 0, ($urandom % 5) == 0, $urandom % 24);

        // Clear a full wave and watch the respawn
        do_reset(2);
        repeat (NE) drive(1, 0, 0);
        for (int i = 0; i < NE; i++) drive(1, 1, i);
        pulses = 0;
        repeat (40) begin
            drive(1, 0, 0);
            if (wd0) pulses++;
        end
        chk("wave_done_pulses", pulses, 1);
        repeat (30) drive(1, 0, 0);
        chk("respawn_alive", al0, 17'h1FFFF);

        // Reset in the middle of a load
        do_reset(2);
        repeat (5) drive(1, 0, 0);
        do_reset(2);
        repeat (NE + 40) drive(1, 0, 0);

        drive(0, 0, 0);
        @(negedge clk25);
        #1;
        chk("sb0_leftover", q0.size(), 0);
        chk("sb1_leftover", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
